// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file port master.
//   DATA_W     : register data width
//   ADDR_W     : register address width (2**ADDR_W registers)
//   WB_DEPTH   : writeback queue entries (power of 2, >= 2)
//   wb_entry_t : one queued writeback {addr, data}
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_queue.sv
// Circular writeback FIFO.
// All slots and a per-slot valid vector are exposed, so the owner can run
// its own forwarding lookup.
// Ports:
//   clk, reset (async, active-low)
//   push, push_addr, push_data : enqueue at tail (ignored when full)
//   pop                        : dequeue head (ignored when empty)
//   full, empty                : derived from the registered count
//   head_ptr                   : physical index of the oldest entry
//   entry_addr/entry_data      : every slot, indexed physically
//   entry_valid                : slot holds a live (not yet popped) entry
module rf_wb_queue
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W,
    parameter int DEPTH  = rf_pkg::WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [PTR_W-1:0]               head_ptr,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr,
    output logic [DEPTH-1:0][DATA_W-1:0]   entry_data,
    output logic [DEPTH-1:0]               entry_valid
);

    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of 2. A push and a pop
    // never target the same slot: pop needs a non-empty queue and push a
    // non-full one, so head and tail differ whenever both fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count       <= '0;
            entry_addr  <= '0;
            entry_data  <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                entry_addr[tail_ptr]  <= push_addr;
                entry_data[tail_ptr]  <= push_data;
                entry_valid[tail_ptr] <= 1'b1;
                tail_ptr              <= tail_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                entry_valid[head_ptr] <= 1'b0;
                head_ptr              <= head_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_port_master.sv
// Initiator side of the 32x32 register-file interface.
// Writebacks are queued and drained one per cycle into the register file.
// Operand reads complete one cycle after acceptance and are bypassed from
// any queued (not yet written) writeback.
// Ports:
//   clk, reset (async, active-low)
//   op_valid/op_ready/op_rs1/op_rs2       : operand read request
//   rd_valid/rd_ready/rd_data1/rd_data2   : operand response
//   wb_valid/wb_ready/wb_rd/wb_data       : writeback request
//   rf_addr1/rf_addr2/rf_dout1/rf_dout2   : register file read ports
//   rf_addrw/rf_din/rf_wren               : register file write port
//   idle                                  : queue empty and no response held
module regfile_port_master
    import rf_pkg::*;
#(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int WB_DEPTH = rf_pkg::WB_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] rf_addr1,
    output logic [ADDR_W-1:0] rf_addr2,
    output logic [ADDR_W-1:0] rf_addrw,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_wren,
    input  logic [DATA_W-1:0] rf_dout1,
    input  logic [DATA_W-1:0] rf_dout2,
    output logic              idle
);

    localparam int PTR_W = $clog2(WB_DEPTH);

    logic                             q_full;
    logic                             q_empty;
    logic                             q_push;
    logic [PTR_W-1:0]                 q_head;
    logic [WB_DEPTH-1:0][ADDR_W-1:0]  q_addr;
    logic [WB_DEPTH-1:0][DATA_W-1:0]  q_data;
    logic [WB_DEPTH-1:0]              q_valid;
    logic [PTR_W-1:0]                 age_idx;
    logic [DATA_W-1:0]                fwd1;
    logic [DATA_W-1:0]                fwd2;
    logic                             op_accept;

    // Writes to r0 are accepted but never queued, since r0 always reads 0.
    assign wb_ready = ~q_full;
    assign q_push   = wb_valid & wb_ready & (wb_rd != '0);

    rf_wb_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WB_DEPTH)
    ) u_wb_queue (
        .clk         (clk),
        .reset       (reset),
        .push        (q_push),
        .push_addr   (wb_rd),
        .push_data   (wb_data),
        .pop         (~q_empty),
        .full        (q_full),
        .empty       (q_empty),
        .head_ptr    (q_head),
        .entry_addr  (q_addr),
        .entry_data  (q_data),
        .entry_valid (q_valid)
    );

    // The head is written at the coming edge, so the register file still
    // holds the old value this cycle. Stale slot contents are masked once the
    // queue runs empty.
    assign rf_wren  = ~q_empty;
    assign rf_addrw = q_empty ? '0 : q_addr[q_head];
    assign rf_din   = q_empty ? '0 : q_data[q_head];

    assign rf_addr1 = op_rs1;
    assign rf_addr2 = op_rs2;

    // Walk the queue from oldest to youngest so that a later match overrides
    // an earlier one. The head is included because its write has not landed
    // yet. The incoming wb_* is deliberately excluded: it is younger than this
    // read in program order.
    always_comb begin
        fwd1    = rf_dout1;
        fwd2    = rf_dout2;
        age_idx = q_head;
        for (int k = 0; k < WB_DEPTH; k++) begin
            age_idx = q_head + PTR_W'(k);
            if (q_valid[age_idx] && (q_addr[age_idx] == op_rs1)) begin
                fwd1 = q_data[age_idx];
            end
            if (q_valid[age_idx] && (q_addr[age_idx] == op_rs2)) begin
                fwd2 = q_data[age_idx];
            end
        end
        if (op_rs1 == '0) begin
            fwd1 = '0;
        end
        if (op_rs2 == '0) begin
            fwd2 = '0;
        end
    end

    assign op_ready  = ~rd_valid | rd_ready;
    assign op_accept = op_valid & op_ready;

    // Response register: data loads only on acceptance and otherwise holds,
    // so it stays stable while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else if (op_accept) begin
            rd_valid <= 1'b1;
            rd_data1 <= fwd1;
            rd_data2 <= fwd2;
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    assign idle = q_empty & ~rd_valid;

endmodule

// File: tb/tb_regfile_port_master.sv
// Testbench for regfile_port_master.
// A behavioural register file is attached to the rf_* ports. The reference
// model tracks the architectural register state (the latest accepted write)
// and the ordered list of writes still owed to the register file.
module tb_regfile_port_master;
    import rf_pkg::*;

    logic              clk;
    logic              reset;
    logic              op_valid;
    logic              op_ready;
    logic [ADDR_W-1:0] op_rs1;
    logic [ADDR_W-1:0] op_rs2;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rf_addr1;
    logic [ADDR_W-1:0] rf_addr2;
    logic [ADDR_W-1:0] rf_addrw;
    logic [DATA_W-1:0] rf_din;
    logic              rf_wren;
    logic [DATA_W-1:0] rf_dout1;
    logic [DATA_W-1:0] rf_dout2;
    logic              idle;

    int vectors;
    int miscompares;

    regfile_port_master dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_rs1   (op_rs1),
        .op_rs2   (op_rs2),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rf_addr1 (rf_addr1),
        .rf_addr2 (rf_addr2),
        .rf_addrw (rf_addrw),
        .rf_din   (rf_din),
        .rf_wren  (rf_wren),
        .rf_dout1 (rf_dout1),
        .rf_dout2 (rf_dout2),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 32x32 register file: combinational reads, write at the edge.
    logic [DATA_W-1:0] regs [32];
    always @(posedge clk) begin
        if (rf_wren && rf_addrw != '0) regs[rf_addrw] <= rf_din;
    end
    assign rf_dout1 = regs[rf_addr1];
    assign rf_dout2 = regs[rf_addr2];

    // Reference model state.
    logic [DATA_W-1:0] arch [32];
    logic [DATA_W-1:0] committed [32];
    wb_entry_t         pending_q [$];
    logic              pend_valid;
    logic [DATA_W-1:0] pend_d1;
    logic [DATA_W-1:0] pend_d2;

    typedef struct {
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic        opv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdr;
        logic        e_wren;
        logic [4:0]  e_addrw;
        logic [31:0] e_din;
        logic        e_rdv;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
    } vec_t;

    vec_t tbl [8];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wbv, input logic [4:0] wbrd, input logic [31:0] wbdata,
                                 input logic opv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic rdr);
        wb_valid = wbv;
        wb_rd    = wbrd;
        wb_data  = wbdata;
        op_valid = opv;
        op_rs1   = rs1;
        op_rs2   = rs2;
        rd_ready = rdr;
    endtask

    // Called at the falling edge: compares outputs with the model, advances
    // the model by one clock, and returns just after the next rising edge.
    task automatic checkOutput();
        logic exp_op_ready;
        logic exp_wb_ready;
        exp_op_ready = !pend_valid || rd_ready;
        exp_wb_ready = (pending_q.size() < WB_DEPTH);
        checkVal("op_ready", op_ready, exp_op_ready);
        checkVal("wb_ready", wb_ready, exp_wb_ready);
        checkVal("rf_wren", rf_wren, pending_q.size() != 0);
        if (pending_q.size() != 0) begin
            checkVal("rf_addrw", rf_addrw, pending_q[0].addr);
            checkVal("rf_din", rf_din, pending_q[0].data);
        end else begin
            checkVal("rf_addrw", rf_addrw, 0);
            checkVal("rf_din", rf_din, 0);
        end
        checkVal("rd_valid", rd_valid, pend_valid);
        if (pend_valid) begin
            checkVal("rd_data1", rd_data1, pend_d1);
            checkVal("rd_data2", rd_data2, pend_d2);
        end
        checkVal("idle", idle, pending_q.size() == 0 && !pend_valid);
        checkVal("rf_addr1", rf_addr1, op_rs1);
        checkVal("rf_addr2", rf_addr2, op_rs2);

        // A read sees every write accepted before it, never the same-cycle one.
        if (op_valid && exp_op_ready) begin
            pend_valid = 1'b1;
            pend_d1    = arch[op_rs1];
            pend_d2    = arch[op_rs2];
        end else if (rd_ready) begin
            pend_valid = 1'b0;
        end
        if (pending_q.size() != 0) begin
            committed[pending_q[0].addr] = pending_q[0].data;
            void'(pending_q.pop_front());
        end
        if (wb_valid && exp_wb_ready && wb_rd != 0) begin
            pending_q.push_back('{addr: wb_rd, data: wb_data});
            arch[wb_rd] = wb_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_rf_wren"}, rf_wren, 0);
        checkVal({tag, "_rf_addrw"}, rf_addrw, 0);
        checkVal({tag, "_rf_din"}, rf_din, 0);
        checkVal({tag, "_rd_valid"}, rd_valid, 0);
        checkVal({tag, "_rd_data1"}, rd_data1, 0);
        checkVal({tag, "_rd_data2"}, rd_data2, 0);
        checkVal({tag, "_idle"}, idle, 1);
        checkVal({tag, "_wb_ready"}, wb_ready, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            regs[i]      = '0;
            arch[i]      = '0;
            committed[i] = '0;
        end
        pend_valid = 1'b0;
        pend_d1    = '0;
        pend_d2    = '0;

        // Directed sequence: back-to-back writebacks, reads with bypass from
        // the head, youngest-wins on a repeated destination, r0 dropped.
        tbl[0] = '{1'b1, 5'd1,  32'd10,  1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'd0,   1'b0, 32'd0,   32'd0};
        tbl[1] = '{1'b1, 5'd2,  32'd20,  1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd1,  32'd10,  1'b0, 32'd0,   32'd0};
        tbl[2] = '{1'b1, 5'd14, 32'd300, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd2,  32'd20,  1'b0, 32'd0,   32'd0};
        tbl[3] = '{1'b1, 5'd14, 32'd400, 1'b0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd14, 32'd300, 1'b1, 32'd10,  32'd20};
        tbl[4] = '{1'b1, 5'd0,  32'd5,   1'b1, 5'd14, 5'd0,  1'b1, 1'b1, 5'd14, 32'd400, 1'b0, 32'd10,  32'd20};
        tbl[5] = '{1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'd0,   1'b1, 32'd400, 32'd0};
        tbl[6] = '{1'b0, 5'd0,  32'd0,   1'b1, 5'd1,  5'd14, 1'b1, 1'b0, 5'd0,  32'd0,   1'b0, 32'd400, 32'd0};
        tbl[7] = '{1'b0, 5'd0,  32'd0,   1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  32'd0,   1'b1, 32'd10,  32'd400};

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        checkVal("reset_op_ready", op_ready, 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].wbv, tbl[i].wbrd, tbl[i].wbdata, tbl[i].opv,
                          tbl[i].rs1, tbl[i].rs2, tbl[i].rdr);
            @(negedge clk);
            checkVal($sformatf("tbl%0d_rf_wren", i), rf_wren, tbl[i].e_wren);
            checkVal($sformatf("tbl%0d_rf_addrw", i), rf_addrw, tbl[i].e_addrw);
            checkVal($sformatf("tbl%0d_rf_din", i), rf_din, tbl[i].e_din);
            checkVal($sformatf("tbl%0d_rd_valid", i), rd_valid, tbl[i].e_rdv);
            checkVal($sformatf("tbl%0d_rd_data1", i), rd_data1, tbl[i].e_d1);
            checkVal($sformatf("tbl%0d_rd_data2", i), rd_data2, tbl[i].e_d2);
            checkOutput();
        end

        // Burst of back-to-back writebacks: drain keeps pace, order preserved.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 5'(3 + i), 32'(1000 + i), 0, 0, 0, 1);
            @(negedge clk);
            checkVal($sformatf("burst%0d_wb_ready", i), wb_ready, 1);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput();

        // Backpressure: response held while rd_ready is low, then a new
        // request is taken in the same cycle the old response is consumed.
        applyStimulus(0, 0, 0, 1, 5'd3, 5'd4, 0);
        @(negedge clk);
        checkOutput();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 5'd5, 5'd6, 0);
            @(negedge clk);
            checkVal("bp_op_ready_low", op_ready, 0);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 1, 5'd5, 5'd6, 1);
        @(negedge clk);
        checkVal("bp_op_ready_release", op_ready, 1);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput();

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
            @(negedge clk);
            checkOutput();
        end

        // Mid-operation reset with a writeback at the queue head: it must be
        // discarded and the port must stay quiet afterwards.
        applyStimulus(1, 5'd5, 32'h0000_abcd, 1, 5'd6, 5'd7, 0);
        @(negedge clk);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        pending_q.delete();
        pend_valid = 1'b0;
        for (int i = 0; i < 32; i++) arch[i] = committed[i];
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            checkVal("post_reset_rf_wren", rf_wren, 0);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 1);
        @(negedge clk);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
